// File: rtl/onehot_hold_decoder_pkg.sv
// Shared types and defaults for the one-hot hold decoder.
// The GUARD state exists only to separate grants when ONEHOT_GUARD_EN is defined.
package onehot_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, GUARD} state_e;
  localparam int N_DEF    = 4;
  localparam int HOLD_DEF = 3;
endpackage

// File: rtl/onehot_hold_decoder_if.sv
// Index-in / grant-out bundle for onehot_hold_decoder.
interface onehot_hold_decoder_if #(
  parameter int N = 4,
  parameter int W = $clog2(N)
);
  logic         in_valid;
  logic [W-1:0] in_code;
  logic         in_zero;
  logic         in_ready;
  logic [N-1:0] y;
  logic         y_valid;
  logic         err;

  modport master (output in_valid, in_code, in_zero, input in_ready, y, y_valid, err);
  modport slave  (input in_valid, in_code, in_zero, output in_ready, y, y_valid, err);
endinterface

// File: rtl/onehot_hold_decoder_bin2onehot.sv
// Combinational binary-to-one-hot decoder; codes >= N give all-zero plus oor.
module bin2onehot #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] code,
  output logic [N-1:0] onehot,
  output logic         oor
);
  always_comb begin
    oor = (int'(code) >= N);
    for (int i = 0; i < N; i++) onehot[i] = (int'(code) == i);
  end
endmodule

// File: rtl/onehot_hold_decoder.sv
// Holds each accepted index as a registered one-hot grant for HOLD cycles.
// Build option: ONEHOT_GUARD_EN inserts a GUARD cycle after every grant.
module onehot_hold_decoder
  import onehot_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = $clog2(N),
  parameter int HOLD = HOLD_DEF
) (
  input logic clk,
  input logic reset_n,
  onehot_hold_decoder_if.slave bus
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  y_q, dec;
  logic          yv_q, err_q, oor;
  logic          last, ready, acc, good, bad;

  bin2onehot #(.N(N), .W(W)) u_dec (.code(bus.in_code), .onehot(dec), .oor(oor));

  assign last = (cnt == '0);

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
`ifdef ONEHOT_GUARD_EN
      DRIVE:   ready = 1'b0;
`else
      DRIVE:   ready = last;
`endif
      default: ready = 1'b0;
    endcase
  end

  // in_zero masks in_code entirely, including its range check
  assign acc  = bus.in_valid & ready;
  assign good = acc & ~bus.in_zero & ~oor;
  assign bad  = acc & ~bus.in_zero & oor;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      y_q   <= '0;
      yv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (bad) err_q <= 1'b1;
      case (state)
        IDLE: if (good) begin
          y_q   <= dec;
          yv_q  <= 1'b1;
          cnt   <= CW'(HOLD - 1);
          state <= DRIVE;
        end
        DRIVE: begin
          if (!last) cnt <= cnt - 1'b1;
`ifdef ONEHOT_GUARD_EN
          else begin
            y_q   <= '0;
            yv_q  <= 1'b0;
            state <= GUARD;
          end
`else
          else if (good) begin
            y_q <= dec;
            cnt <= CW'(HOLD - 1);
          end else begin
            y_q   <= '0;
            yv_q  <= 1'b0;
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.y        = y_q;
  assign bus.y_valid  = yv_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_onehot_hold_decoder.sv
// Two decoders side by side (N=4/HOLD=3 and N=3/HOLD=1) against a grant-timeline model.
module tb_onehot_hold_decoder;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

`ifdef ONEHOT_GUARD_EN
  localparam bit GUARD_B = 1'b1;
`else
  localparam bit GUARD_B = 1'b0;
`endif

  onehot_hold_decoder_if #(.N(4)) ifa ();
  onehot_hold_decoder_if #(.N(3)) ifb ();

  onehot_hold_decoder #(.N(4), .HOLD(3)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  onehot_hold_decoder #(.N(3), .HOLD(1)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  int ncmp = 0, nmis = 0;

  // model: current grant index (-1 = none), output cycles left for it, pending zero gap
  int mn[2]   = '{4, 3};
  int mh[2]   = '{3, 1};
  int cur[2]  = '{-1, -1};
  int left[2] = '{0, 0};
  int gap[2]  = '{0, 0};
  bit merr[2] = '{0, 0};
  bit last_acc[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int k);
    return (cur[k] < 0 && gap[k] == 0) || (cur[k] >= 0 && left[k] == 1 && !GUARD_B);
  endfunction

  function automatic logic [31:0] m_y(input int k);
    return (cur[k] < 0) ? 32'd0 : (32'd1 << cur[k]);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      cur[k] = -1; left[k] = 0; gap[k] = 0; merr[k] = 1'b0;
    end
  endtask

  task automatic m_step(input int k, input bit v, input bit z, input int c);
    bit acc;
    acc = v && m_ready(k);
    if (cur[k] >= 0) begin
      left[k]--;
      if (left[k] == 0) begin
        cur[k] = -1;
        if (GUARD_B) gap[k] = 1;
      end
    end else if (gap[k] > 0) gap[k]--;
    if (acc && !z) begin
      if (c >= mn[k]) merr[k] = 1'b1;
      else begin cur[k] = c; left[k] = mh[k]; end
    end
    last_acc[k] = acc;
  endtask

  task automatic check_one(input int k, input logic [31:0] y, input logic yv, input logic rdy, input logic e);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".y"}, y, m_y(k));
    chk({p, ".y_valid"}, 32'(yv), 32'(cur[k] >= 0));
    chk({p, ".in_ready"}, 32'(rdy), 32'(m_ready(k)));
    chk({p, ".err"}, 32'(e), 32'(merr[k]));
  endtask

  task automatic check_all();
    check_one(0, 32'(ifa.y), ifa.y_valid, ifa.in_ready, ifa.err);
    check_one(1, 32'(ifb.y), ifb.y_valid, ifb.in_ready, ifb.err);
  endtask

  task automatic step(input bit v0, input bit z0, input int c0, input bit v1, input bit z1, input int c1);
    @(negedge clk);
    check_all();
    ifa.in_valid = v0; ifa.in_zero = z0; ifa.in_code = 2'(c0);
    ifb.in_valid = v1; ifb.in_zero = z1; ifb.in_code = 2'(c1);
    @(posedge clk);
    m_step(0, v0, z0, c0);
    m_step(1, v1, z1, c1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_zero = 1'b0; ifa.in_code = '0;
    ifb.in_valid = 1'b0; ifb.in_zero = 1'b0; ifb.in_code = '0;
    m_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // single grant on a; out-of-range 3 then code 1 on b (err must stick)
    step(1, 0, 2, 1, 0, 3);
    step(0, 0, 0, 1, 0, 1);
    idle(4);

    // valid held: 0 then 3 on a; consecutive codes 0,1,2 on b
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 3, 1, 0, 1);
    for (int i = 0; i < 10 && !last_acc[0]; i++) step(1, 0, 3, (i == 0), 0, 2);
    idle(6);

    // in_zero masks in_code
    step(1, 1, 1, 1, 1, 1);
    idle(2);

    // asynchronous reset in the 2nd cycle of a grant
    step(1, 0, 2, 1, 0, 3);
    step(0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst.a.y", 32'(ifa.y), 32'd0);
    chk("rst.a.y_valid", 32'(ifa.y_valid), 32'd0);
    chk("rst.b.err", 32'(ifb.err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 1, 0, 0, 0);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 1), ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
           $urandom_range(0, 1), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule

// File: doc/onehot_hold_decoder.md
# onehot_hold_decoder

- Converts a binary index stream back into a registered one-hot grant vector, the inverse of the team's one-hot priority encoder.
- Each accepted index is held on the output for a fixed number of cycles.
- Sits downstream of the encoder/arbiter path and drives the grant lines of the selected requester.
- Input side uses a valid/ready handshake so the upstream block can be stalled while a grant is being held.

## Interface
Parameters:
- N, 4, number of one-hot output lines (N ≥ 2)
- W, $clog2(N), index width
- HOLD, 3, cycles each grant is held on y (HOLD ≥ 1)

Ports:
- clk  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  index present on in_code
- in_code  input  W  binary index of line to grant
- in_zero  input  1  "no request" marker (encoder all-zero case); valid only with in_valid
- in_ready  output  1  block can accept an index this cycle
- y  output  N  registered one-hot grant vector
- y_valid  output  1  y carries a live grant
- err  output  1  sticky flag, out-of-range index seen

## Operation
- Reset values: y = 0, y_valid = 0, err = 0, state = IDLE, hold counter = 0. in_ready = 1 is combinational from IDLE.
- Accept: occurs when in_valid & in_ready are both high at a rising edge.
- IDLE:
  - in_ready = 1.
  - On accept with in_zero = 1: y stays 0 and the state stays IDLE.
  - On accept with in_code ≥ N: y stays 0, the state stays IDLE, and err is set.
  - Otherwise: y ← 1 << in_code, y_valid ← 1, cnt ← HOLD−1, state → DRIVE.
- DRIVE:
  - y is held.
  - While cnt > 0: in_ready = 0 and cnt decrements each edge.
  - Last cycle (cnt == 0), without GUARD_EN:
    - in_ready = 1.
    - Accept with a valid index reloads y/cnt and stays in DRIVE (back-to-back grants, no gap).
    - Accept with zero or out-of-range: y ← 0, y_valid ← 0, state → IDLE, err updated as in IDLE.
    - No accept: y ← 0, y_valid ← 0, state → IDLE.
- in_zero has priority over in_code; in_code is ignored when in_zero = 1.
- err clears only on reset.
- Exactly one bit of y is high whenever y_valid = 1. y = 0 whenever y_valid = 0.

## Timing
- Latency: y is valid starting the cycle after the accept edge k. It is held through edge k+HOLD.
- Back-to-back (no GUARD_EN): the next accept can occur at edge k+HOLD, giving contiguous grants. Sustained throughput is one index per HOLD cycles.
- HOLD = 1: in_ready is constantly 1. y follows each accepted index with one-cycle latency.
- Reset mid-DRIVE: y, y_valid, err and cnt clear immediately (asynchronously). The first edge after reset_n rises sees IDLE.
- in_valid may drop without being accepted. No input is latched unless an accept occurs.

## Configuration
- Macro: ONEHOT_GUARD_EN.
- Defined:
  - GUARD state is added after DRIVE.
  - In the last DRIVE cycle in_ready = 0. At the end of that cycle y ← 0, y_valid ← 0, state → GUARD.
  - GUARD lasts exactly one cycle with in_ready = 0, then → IDLE.
  - Result: at least two all-zero cycles between consecutive grants (one GUARD cycle and one IDLE cycle), and throughput is one index per HOLD+2 cycles.
- Undefined: no GUARD state, behaviour as above.

## Structure
- Package onehot_pkg:
  - state enum typedef (IDLE, DRIVE, GUARD). GUARD is always declared and only used with the macro.
  - default N and HOLD constants.
- Sub-module bin2onehot:
  - parameterized N/W combinational decoder.
  - outputs the one-hot vector plus an out-of-range flag.
  - instantiated once, ahead of the y register.

## Test plan
- Reset, then in_code = 2, in_valid for 1 cycle -> y = 4'b0100 and y_valid = 1 for exactly 3 cycles starting the cycle after the accept; in_ready low for the first 2 of those cycles.
- in_valid held with codes 0 then 3, no GUARD_EN -> y = 0001 ×3 then 1000 ×3 contiguous. With ONEHOT_GUARD_EN -> two all-zero cycles between them.
- Accept with in_zero = 1, in_code = 1 -> y stays 0000, y_valid 0, in_ready stays 1.
- N = 3 build, in_code = 3 -> y = 000, err = 1 and err remains 1 after a subsequent valid code 1 (y = 010).
- reset_n pulled low in the 2nd cycle of a grant -> y = 0, y_valid = 0, err = 0 immediately; after release, first accept of code 1 gives y = 0010 the next cycle.
- HOLD = 1 build, codes 0,1,2,3 on consecutive cycles -> y = 0001, 0010, 0100, 1000 on consecutive cycles; in_ready constantly 1.
